// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared 640x480@60 timing constants, pattern mode encodings and bar colours.
package video_timing_pkg;
  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_TOT  = 800;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_TOT  = 525;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_RGB = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                          RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
endpackage

// File: rtl/pattern_gen.sv
// pattern_gen: combinational test-pattern colour for the current counter position.
module pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  mode_e       mode_i,
  input  logic [11:0] h_i,
  input  logic [11:0] v_i,
  input  logic [2:0]  bar_i,
  input  logic        active_i,
  input  logic [23:0] solid_rgb_i,
  output logic [23:0] rgb_o
);
  localparam logic [11:0] H_LAST = 12'(H_RES - 1);
  localparam logic [11:0] V_LAST = 12'(V_RES - 1);

  logic grid_on;

  assign grid_on = h_i[4:0] == 5'd0 || v_i[4:0] == 5'd0 || h_i == H_LAST || v_i == V_LAST;

  always_comb begin
    rgb_o = !active_i                ? RGB_BLACK :
            mode_i == MODE_BARS      ? BAR_RGB[bar_i] :
            mode_i == MODE_GRID      ? {24{grid_on}} :
            mode_i == MODE_SOLID     ? solid_rgb_i :
                                       {3{h_i[7:0]}};
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing with registered sync, coordinates and test pattern.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_RES  = DEF_V_RES,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        de,
  output logic        hs,
  output logic        vs,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
);
  localparam logic [11:0] H_ACT  = 12'(H_RES);
  localparam logic [11:0] V_ACT  = 12'(V_RES);
  localparam logic [11:0] H_TOT  = 12'(H_RES + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOT  = 12'(V_RES + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] HS_BEG = 12'(H_RES + H_FP);
  localparam logic [11:0] HS_END = 12'(H_RES + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_RES + V_FP);
  localparam logic [11:0] VS_END = 12'(V_RES + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W  = 12'(H_RES / 8);

  logic [11:0] h_q, h_d, v_q, v_d, seg_q, seg_d;
  logic [2:0]  bar_q, bar_d;
  mode_e       mode_q, mode_d;
  logic        h_wrap, v_wrap, bar_step, origin, active, hs_d, vs_d;
  logic [23:0] rgb_d, rgb_q;
  logic        de_q, hs_q, vs_q, fs_q;
  logic [11:0] x_q, y_q;

  // The frame's first pixel already uses the freshly sampled mode.
  always_comb begin
    h_wrap   = h_q == H_TOT - 12'd1;
    v_wrap   = v_q == V_TOT - 12'd1;
    bar_step = seg_q == BAR_W - 12'd1;
    origin   = h_q == 12'd0 && v_q == 12'd0;
    active   = h_q < H_ACT && v_q < V_ACT;
    mode_d   = origin ? mode_e'(mode) : mode_q;
    h_d      = h_wrap ? 12'd0 : h_q + 12'd1;
    v_d      = h_wrap ? (v_wrap ? 12'd0 : v_q + 12'd1) : v_q;
    seg_d    = (h_wrap || bar_step) ? 12'd0 : seg_q + 12'd1;
    bar_d    = h_wrap ? 3'd0 : bar_step ? bar_q + 3'd1 : bar_q;
    hs_d     = (h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
    vs_d     = (v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
  end

  pattern_gen #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_pattern (
    .mode_i     (mode_d),
    .h_i        (h_q),
    .v_i        (v_q),
    .bar_i      (bar_q),
    .active_i   (active),
    .solid_rgb_i(solid_rgb),
    .rgb_o      (rgb_d)
  );

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      seg_q  <= '0;
      bar_q  <= '0;
      mode_q <= MODE_BARS;
      de_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      seg_q  <= seg_d;
      bar_q  <= bar_d;
      mode_q <= mode_d;
      de_q   <= active;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= origin;
      rgb_q  <= rgb_d;
      x_q    <= h_q;
      y_q    <= v_q;
    end
  end

  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign {r, g, b}   = rgb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: default and small-raster instances checked every cycle against a pixel-index model.
module tb_video_timing_gen;
  typedef struct {
    int hr, hf, hsy, hb, vr, vf, vsy, vb;
    bit hp, vp;
  } tp_t;

  tp_t pd = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  tp_t ps = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d = 1'b1, rst_s = 1'b1;
  logic [1:0]  mode_d = 2'd0, mode_s = 2'd0;
  logic [23:0] solid_d = 24'h0, solid_s = 24'h0;
  logic        de_d, hs_d, vs_d, fs_d, de_s, hs_s, vs_s, fs_s;
  logic [7:0]  r_d, g_d, b_d, r_s, g_s, b_s;
  logic [11:0] x_d, y_d, x_s, y_s;
  logic [51:0] pk_d, pk_s;
  int n_chk = 0, n_fail = 0;

  video_timing_gen u_def (
    .pix_clk(clk), .rst(rst_d), .mode(mode_d), .solid_rgb(solid_d),
    .de(de_d), .hs(hs_d), .vs(vs_d), .r(r_d), .g(g_d), .b(b_d),
    .x(x_d), .y(y_d), .frame_start(fs_d)
  );

  video_timing_gen #(
    .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (
    .pix_clk(clk), .rst(rst_s), .mode(mode_s), .solid_rgb(solid_s),
    .de(de_s), .hs(hs_s), .vs(vs_s), .r(r_s), .g(g_s), .b(b_s),
    .x(x_s), .y(y_s), .frame_start(fs_s)
  );

  assign pk_d = {de_d, hs_d, vs_d, fs_d, x_d, y_d, r_d, g_d, b_d};
  assign pk_s = {de_s, hs_s, vs_s, fs_s, x_s, y_s, r_s, g_s, b_s};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int tot(tp_t p);
    return (p.hr + p.hf + p.hsy + p.hb) * (p.vr + p.vf + p.vsy + p.vb);
  endfunction

  function automatic logic [23:0] bar_col(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected output word for the pixel with linear index pos in its frame (-1 = held in reset).
  function automatic logic [51:0] expect_px(tp_t p, int pos, logic [1:0] m, logic [23:0] sol);
    int ht, px, py;
    logic act, h, v;
    logic [23:0] c;
    if (pos < 0) return {1'b0, ~p.hp, ~p.vp, 1'b0, 48'h0};
    ht  = p.hr + p.hf + p.hsy + p.hb;
    px  = pos % ht;
    py  = pos / ht;
    act = px < p.hr && py < p.vr;
    h   = (px >= p.hr + p.hf && px < p.hr + p.hf + p.hsy) ? p.hp : ~p.hp;
    v   = (py >= p.vr + p.vf && py < p.vr + p.vf + p.vsy) ? p.vp : ~p.vp;
    c   = 24'h0;
    if (act) begin
      case (m)
        2'd0: c = bar_col(px / (p.hr / 8));
        2'd1: c = (px % 32 == 0 || py % 32 == 0 || px == p.hr - 1 || py == p.vr - 1) ? 24'hFFFFFF : 24'h0;
        2'd2: c = sol;
        default: c = {3{8'(px % 256)}};
      endcase
    end
    return {act, h, v, pos == 0, 12'(px), 12'(py), c};
  endfunction

  int pos_d = -1, pos_s = -1;
  logic [1:0] fm_d = 2'd0, fm_s = 2'd0;
  logic [23:0] sl_d = 24'h0, sl_s = 24'h0;
  bit go = 1'b0;

  always @(posedge clk) begin
    go    = 1'b1;
    pos_d = rst_d ? -1 : (pos_d + 1) % tot(pd);
    if (pos_d == 0) fm_d = mode_d;
    sl_d  = solid_d;
    pos_s = rst_s ? -1 : (pos_s + 1) % tot(ps);
    if (pos_s == 0) fm_s = mode_s;
    sl_s  = solid_s;
  end

  always @(negedge clk) begin
    if (go) begin
      check("px_def", 64'(pk_d), 64'(expect_px(pd, pos_d, fm_d, sl_d)));
      check("px_small", 64'(pk_s), 64'(expect_px(ps, pos_s, fm_s, sl_s)));
    end
  end

  task automatic wait_d(input int wx, input int wy);
    bit found = 1'b0;
    for (int k = 0; k < 6000 && !found; k++) begin
      @(negedge clk);
      found = x_d == 12'(wx) && y_d == 12'(wy);
    end
    check("wait_def", 64'(found), 64'd1);
  endtask

  task automatic wait_s(input int wx, input int wy);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      found = x_s == 12'(wx) && y_s == 12'(wy);
    end
    check("wait_small", 64'(found), 64'd1);
  endtask

  task automatic run_def();
    int n;
    solid_d = 24'hA5C3E1;
    repeat (3) @(negedge clk);
    check("def_reset", 64'(pk_d), 64'({1'b0, 1'b1, 1'b1, 1'b0, 48'h0}));
    rst_d = 1'b0;
    @(negedge clk);
    check("def_release", 64'({de_d, fs_d, x_d, y_d}), 64'({1'b1, 1'b1, 24'h0}));
    wait_d(79, 0);  check("bar0_end", 64'({r_d, g_d, b_d}), 64'h FFFFFF);
    wait_d(80, 0);  check("bar1_start", 64'({r_d, g_d, b_d}), 64'h FFFF00);
    wait_d(560, 0); check("bar7_start", 64'({r_d, g_d, b_d}), 64'h0);
    wait_d(640, 0); check("blank_rgb", 64'({de_d, r_d, g_d, b_d}), 64'h0);
    n = 0;
    while (hs_d && n < 200) begin @(negedge clk); n++; end
    check("hs_start_x", 64'(x_d), 64'd656);
    n = 0;
    while (!hs_d && n < 200) begin @(negedge clk); n++; end
    check("hs_width", 64'(n), 64'd96);
    wait_d(100, 1);
    mode_d = 2'd3;
    wait_d(120, 1); check("bars_hold", 64'({r_d, g_d, b_d}), 64'h FFFF00);
    wait_d(300, 1);
    rst_d = 1'b1;
    @(negedge clk);
    check("def_mid_reset", 64'(pk_d), 64'({1'b0, 1'b1, 1'b1, 1'b0, 48'h0}));
    rst_d = 1'b0;
    @(negedge clk);
    check("def_restart", 64'({de_d, fs_d, x_d, y_d}), 64'({1'b1, 1'b1, 24'h0}));
    wait_d(255, 0); check("ramp_255", 64'({r_d, g_d, b_d}), 64'h FFFFFF);
    wait_d(256, 0); check("ramp_256", 64'({r_d, g_d, b_d}), 64'h0);
    mode_d = 2'd1;
    rst_d = 1'b1;
    @(negedge clk);
    rst_d = 1'b0;
    wait_d(32, 5);  check("grid_32_5", 64'({r_d, g_d, b_d}), 64'h FFFFFF);
    wait_d(33, 5);  check("grid_33_5", 64'({r_d, g_d, b_d}), 64'h0);
    wait_d(639, 5); check("grid_639_5", 64'({r_d, g_d, b_d}), 64'h FFFFFF);
    wait_d(100, 7); check("grid_100_7", 64'({r_d, g_d, b_d}), 64'h0);
  endtask

  task automatic run_small();
    int de_c, fs_c;
    repeat (3) @(negedge clk);
    check("small_reset", 64'(pk_s), 64'h0);
    rst_s = 1'b0;
    @(negedge clk);
    check("small_release", 64'({de_s, fs_s, x_s, y_s}), 64'({1'b1, 1'b1, 24'h0}));
    de_c = 1;
    fs_c = 1;
    repeat (83) begin
      @(negedge clk);
      de_c += int'(de_s);
      fs_c += int'(fs_s);
    end
    check("small_de_per_frame", 64'(de_c), 64'd32);
    check("small_fs_per_frame", 64'(fs_c), 64'd1);
    @(negedge clk);
    check("small_frame_period", 64'({fs_s, x_s, y_s}), 64'({1'b1, 24'h0}));
    wait_s(9, 1);  check("small_hs_9", 64'(hs_s), 64'd1);
    wait_s(10, 1); check("small_hs_10", 64'(hs_s), 64'd1);
    wait_s(11, 1); check("small_hs_11", 64'(hs_s), 64'd0);
    wait_s(8, 2);  check("small_hs_8", 64'(hs_s), 64'd0);
    wait_s(11, 4); check("small_vs_4", 64'(vs_s), 64'd0);
    wait_s(0, 5);  check("small_vs_5a", 64'(vs_s), 64'd1);
    wait_s(11, 5); check("small_vs_5b", 64'(vs_s), 64'd1);
    wait_s(0, 6);  check("small_vs_6", 64'(vs_s), 64'd0);
    wait_s(0, 0);  check("small_bars_00", 64'({r_s, g_s, b_s}), 64'h FFFFFF);
    wait_s(3, 1);
    mode_s  = 2'd2;
    solid_s = 24'h123456;
    wait_s(0, 2);  check("small_hold_0_2", 64'({r_s, g_s, b_s}), 64'h FFFFFF);
    wait_s(7, 3);  check("small_hold_7_3", 64'({r_s, g_s, b_s}), 64'h0);
    wait_s(0, 0);  check("small_solid_00", 64'({fs_s, r_s, g_s, b_s}), 64'h1123456);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) mode_s = 2'($urandom);
      if ($urandom_range(0, 99) < 5) solid_s = 24'($urandom);
      rst_s = $urandom_range(0, 149) == 0;
    end
    rst_s = 1'b0;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    fork
      run_def();
      run_small();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete within 60000 cycles");
    $fatal(1);
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Programmable raster timing and test-pattern generator in the pixel clock domain. Drives `de`/`hs`/`vs` and 8-bit RGB directly into the DVI/HDMI transmitter's `I_rgb_*` inputs. It also exports pixel coordinates and a frame-start strobe so that later overlay or framebuffer stages can lock to the raster. Default parameters give 640x480@60 (800x525 total).

## Interface
Parameters:
- `H_RES` 640 — active pixels per line; must be a multiple of 8
- `H_FP` 16 — horizontal front porch, pixels
- `H_SYNC` 96 — hsync width, pixels
- `H_BP` 48 — horizontal back porch, pixels
- `V_RES` 480 — active lines
- `V_FP` 10 — vertical front porch, lines
- `V_SYNC` 2 — vsync width, lines
- `V_BP` 33 — vertical back porch, lines
- `HS_POL` 0 — hsync active level (0 = negative)
- `VS_POL` 0 — vsync active level

Ports:
- `pix_clk` in 1 — pixel clock; the block's only clock
- `rst` in 1 — synchronous, active-high reset
- `mode` in 2 — pattern select: 0 colour bars, 1 grid, 2 solid, 3 ramp
- `solid_rgb` in 24 — {R,G,B} colour used in mode 2
- `de` out 1 — data enable
- `hs` out 1 — horizontal sync
- `vs` out 1 — vertical sync
- `r`, `g`, `b` out 8 each — pixel colour
- `x`, `y` out 12 each — coordinate of the pixel currently on the outputs
- `frame_start` out 1 — one-cycle pulse accompanying pixel (0,0)

## Operation
- **Counters.**
  - `h_cnt` counts 0..H_TOT-1, with H_TOT = H_RES+H_FP+H_SYNC+H_BP.
  - `v_cnt` counts 0..V_TOT-1 and advances when `h_cnt` wraps.
  - Both wrap to 0 together at the end of the frame.
  - Both are 12-bit; totals must be ≤ 4095.
- **Line and frame layout.** Each is ordered active → front porch → sync → back porch.
  - Active region: `h_cnt` < H_RES and `v_cnt` < V_RES.
  - Hsync asserted for `h_cnt` in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1].
  - Vsync asserted for `v_cnt` in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1] over whole lines, so vs edges coincide with `h_cnt`==0.
- **Sync levels.** Asserted sync = POL value; inactive = ~POL.
- **Mode latch.** `mode` is sampled only when the counters are at (0,0). The latched value holds for the whole frame, so there is no mid-frame tearing. `solid_rgb` is not latched.
- **Patterns.** Evaluated on the counter values; RGB is forced to 0 whenever not in the active region.
  - Mode 0, colour bars: 8 bars of H_RES/8 px, left to right: white, yellow, cyan, green, magenta, red, blue, black. Components are 0xFF/0x00. Bar index comes from a bar counter that resets at `h_cnt`==0 and increments every H_RES/8 pixels. No divider.
  - Mode 1, grid: white where `h_cnt[4:0]`==0, `v_cnt[4:0]`==0, `h_cnt`==H_RES-1, or `v_cnt`==V_RES-1; black elsewhere.
  - Mode 2, solid: `solid_rgb`.
  - Mode 3, ramp: R=G=B=`h_cnt[7:0]`; wraps every 256 px.
- **Outputs.** `x`/`y` = `h_cnt`/`v_cnt` registered alongside the pixel data. `frame_start` = 1 iff the registered counters were (0,0).

## Timing
- **Latency.** All outputs are registered, one `pix_clk` behind the counters, and are mutually aligned. `de`, `hs`, `vs`, RGB, `x`, `y` and `frame_start` always describe the same pixel.
- **Reset values** (while `rst`=1):
  - counters and latched mode: 0
  - `de`, RGB, `x`, `y`, `frame_start`: 0
  - `hs` = ~HS_POL, `vs` = ~VS_POL
- **Release from reset.** At the first edge with `rst`=0, the counters go (0,0)→(1,0). The following cycle shows pixel (0,0): `de`=1, `frame_start`=1, `x`=`y`=0.
- **Reset mid-frame.** Takes effect at the next edge and fully restarts the frame. No partial line or sync pulse is completed.
- **Frame wrap.** (H_TOT-1, V_TOT-1) is followed directly by (0,0). `frame_start` fires exactly once per V_TOT·H_TOT cycles.
- **Mode change.** A change at any other time takes effect on the first pixel of the next frame.
- **Frame length.** The `de` high count per frame is exactly H_RES·V_RES.

## Structure
- **Shared package `video_timing_pkg`:**
  - 640x480@60 timing constants (including 800/525 totals)
  - mode encodings (`MODE_BARS`, `MODE_GRID`, `MODE_SOLID`, `MODE_RAMP`)
  - the 8 bar colours as 24-bit constants
- **Sub-module.** One combinational sub-module, `pattern_gen`: inputs are mode, coordinates, bar index, active flag and `solid_rgb`; output is RGB. Counters, sync decode and output registers stay in `video_timing_gen`.

## Test plan
- Defaults, `rst` held 3 cycles then released → pixel (0,0) one cycle after release with `frame_start`=1. `hs` low for 96 cycles starting at `x`=656 each line. `vs` low for 2 lines at `y`=490..491. Period is 800 cycles/line and 420000 cycles/frame.
- Mode 0, full frame → `de` high 307200 cycles/frame. `x`=0..79 gives 0xFFFFFF, `x`=80 gives 0xFFFF00, `x`=560..639 gives 0x000000. RGB=0 at `x`=640..799.
- `mode` changed 0→2 mid-frame (`solid_rgb`=0x123456) → current frame stays bars. The next frame's (0,0) onward is 0x123456.
- Mode 3 → `x`=255 gives 0xFFFFFF, `x`=256 gives 0x000000. Mode 1 → (32,5) white, (33,5) black, (639,100) white.
- `rst` asserted at (300,200) for 1 cycle → next cycle outputs are the reset values. After release, the raster restarts at (0,0) with `frame_start`.
- Small parameters (H 8/1/2/1, V 4/1/1/1, HS_POL=VS_POL=1) → 12-cycle lines, 7-line frames, positive sync pulses at `x`=9..10 and `y`=5.
